// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and status bundle type.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEF_DEPTH      = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Contents are intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock show-ahead FIFO with count, almost flags and sticky errors.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = FIFO_DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEF_DEPTH,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned AW           = $clog2(FIFO_DEPTH),
  localparam int unsigned CW           = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push, pop;
  fifo_status_t  status;

  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    status              = '0;
    status.full         = (count == CW'(FIFO_DEPTH));
    status.empty        = (count == '0);
    status.almost_full  = (count >= CW'(AFULL_THRESH));
    status.almost_empty = (count <= CW'(AEMPTY_THRESH));
    status.overflow     = ovf_q;
    status.underflow    = udf_q;
  end

  // A simultaneous read frees the slot, so a full FIFO still takes the write.
  // A write into an empty FIFO covers the read attempt: no underflow then.
  always_comb begin
    push     = wr_en && (!status.full || rd_en);
    pop      = rd_en && !status.empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = (ovf_q && !clr_err) || (wr_en && !push);
    udf_d    = (udf_q && !clr_err) || (rd_en && status.empty && !wr_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (dout)
  );

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - directed self-checking bench for param_sync_fifo (8x8, AF=6, AE=2).
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (8),
    .AFULL_THRESH  (6),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      din   = first + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst_n = 1'b1;
    step();

    // Fill 0x01..0x08 and watch the flag thresholds.
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      din   = 8'(i);
      step();
      chk("fill_count", count, i);
      chk("fill_afull", almost_full, (i >= 6));
      chk("fill_aempty", almost_empty, (i <= 2));
      chk("fill_full", full, (i == 8));
      chk("fill_dout", dout, 8'h01);
    end
    din = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    chk("ovf_dout", dout, 8'h01);

    for (int i = 1; i <= 8; i++) begin
      chk("drain_dout", dout, i);
      rd_en = 1'b1;
      step();
      chk("drain_count", count, 8 - i);
    end
    chk("drain_empty", empty, 1);
    step();
    rd_en = 1'b0;
    chk("udf_set", underflow, 1);
    chk("udf_count", count, 0);
    chk("udf_ovf_hold", overflow, 1);

    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    // Full with simultaneous write and read.
    fill_seq(8'h01, 8);
    chk("f2_full", full, 1);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hAA;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("fwr_count", count, 8);
    chk("fwr_full", full, 1);
    chk("fwr_ovf", overflow, 0);
    chk("fwr_dout", dout, 8'h02);
    for (int i = 2; i <= 9; i++) begin
      chk("fwr_drain", dout, (i == 9) ? 8'hAA : 8'(i));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("fwr_empty", empty, 1);

    // Empty with simultaneous write and read.
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("ewr_count", count, 1);
    chk("ewr_dout", dout, 8'h55);
    chk("ewr_udf", underflow, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("ewr_empty", empty, 1);

    // Streaming pairs across three pointer wraps.
    fill_seq(8'h10, 4);
    for (int j = 0; j < 20; j++) begin
      chk("pair_dout", dout, 8'h10 + 8'(j));
      wr_en = 1'b1; rd_en = 1'b1; din = 8'h14 + 8'(j);
      step();
      chk("pair_count", count, 4);
    end
    wr_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("pair_tail", dout, 8'h24 + 8'(j));
      step();
      chk("pair_tail_count", count, 3 - j);
    end
    rd_en = 1'b0;
    chk("pair_empty", empty, 1);
    chk("pair_ovf", overflow, 0);
    chk("pair_udf", underflow, 0);

    // Asynchronous reset mid-cycle with data and a sticky error.
    fill_seq(8'h30, 8);
    wr_en = 1'b1; din = 8'hEE;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step(); step(); step();
    rd_en = 1'b0;
    chk("pre_rst_count", count, 5);
    chk("pre_rst_ovf", overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ovf", overflow, 0);
    step();
    rst_n = 1'b1;
    step();

    // Set wins over clear, then a plain clear.
    fill_seq(8'h40, 8);
    wr_en = 1'b1; clr_err = 1'b1; din = 8'hBB;
    step();
    wr_en = 1'b0;
    chk("setwins_ovf", overflow, 1);
    step();
    clr_err = 1'b0;
    chk("clr2_ovf", overflow, 0);
    chk("clr2_count", count, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
